vga_pixfmt: RTL
===============

# vga_pixfmt

Pixel formatter stage directly downstream of the VGA timing generator. It consumes the generator's `de`/`hsync`/`vsync`/`vend` strobes, pops packed pixel words from the first-word-fall-through (FWFT) pixel FIFO, and unpacks and expands them to RGB888. It drives the registered colour and sync outputs to the DAC/pads, with the syncs delayed so they stay aligned with the pixel data.

## Interface
Parameters:
- `DW`, 32: FIFO word width; fixed at 32, other values unsupported.

Ports:
- `clk_i` in 1: pixel clock; one clock domain.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `en_i` in 1: block enable (same enable as the timing generator).
- `mode_i` in 2: pixel format. `VGA_MODE_RGB888`=0, `VGA_MODE_RGB565`=1, `VGA_MODE_RGB332`=2; 3 is reserved and treated as 0.
- `de_i`, `hsync_i`, `vsync_i`, `vend_i` in 1 each: timing generator outputs. `vend_i` is a one-cycle end-of-frame strobe.
- `fifo_empty_i` in 1: FIFO empty.
- `fifo_data_i` in 32: FIFO head word (FWFT).
- `fifo_rd_o` out 1: pop strobe; combinational.
- `red_o`, `green_o`, `blue_o` out 8 each: registered colour.
- `hsync_o`, `vsync_o`, `de_o` out 1 each: registered, delayed copies of the inputs.
- `underflow_o` out 1: one-cycle pulse, aligned with the black pixel it caused.

## Operation
- Pixels per word (ppw): 1 in RGB888, 2 in RGB565, 4 in RGB332. Pixels are taken from the word starting at the low bits: RGB888 uses bits [23:0] (R=[23:16]) and ignores [31:24]; RGB565 uses the low halfword first; RGB332 uses the low byte first.
- State:
  - `idx_q`: 2-bit pixel index within the current word.
  - `word_q`: 32-bit held word.
  - `mode_q`: latched pixel format.
- Fetch on each `en_i && de_i` cycle:
  - `idx_q==0`: `fifo_rd_o = !fifo_empty_i`. The pixel is taken directly from `fifo_data_i`, and `fifo_data_i` is loaded into `word_q`.
  - `idx_q!=0`: the pixel is taken from `word_q` and `fifo_rd_o` stays 0.
  - Either way, `idx_q` advances by 1 modulo ppw.
- Underflow: `idx_q==0` and `fifo_empty_i` while `de_i`. No pop occurs, the pixel is output black, `underflow_o` pulses, and `idx_q` still advances.
- Packing is continuous across lines; `idx_q` is not reset at line end.
- Expansion to 8 bits per channel uses MSB replication:
  - RGB565: R={r5,r5[4:2]}, G={g6,g6[5:4]}, B={b5,b5[4:2]}.
  - RGB332: R={r3,r3,r3[2:1]}, G likewise, B={b2,b2,b2,b2}.
- `!de_i` cycles: RGB outputs are 0 and no pop occurs.
- Frame boundary (`en_i && vend_i`): `idx_q` is set to 0, `mode_q` is set to `mode_i`, and `word_q` is kept. Any partial word is discarded. `vend_i` takes priority over an advance in the same cycle.
- `en_i` low:
  - `idx_q` is forced to 0 and `mode_q` tracks `mode_i`.
  - No pops occur.
  - RGB outputs, `de_o` and `underflow_o` are 0.
  - `hsync_o`/`vsync_o` still follow their inputs with the same delay.

## Timing
- Latency is 1 cycle: the pixel for the `de_i` cycle n appears on `red_o`/`green_o`/`blue_o` at n+1.
- `hsync_o`, `vsync_o`, `de_o` and `underflow_o` are registered with the same 1-cycle delay.
- `fifo_rd_o` is asserted in cycle n, and the FIFO advances at the cycle-n edge.
- Reset values: all outputs 0 (including the syncs, so pad polarity is defined at reset); `idx_q`=0, `word_q`=0, `mode_q`=0.
- Reset asserted mid-line: all outputs are 0 asynchronously, and the first frame after release starts at `idx_q`=0.
- A `mode_i` change mid-frame is ignored until the next `vend_i`.
- A pop is never issued when `fifo_empty_i`=1, and never two in consecutive cycles unless ppw=1.

## Structure
- `vga_define.sv` gains the `VGA_MODE_*` codes and `VGA_PIX_WIDTH` (24).
- One combinational sub-module, `vga_pixexp`: inputs `mode` and a 32-bit word plus a 2-bit index; output RGB888. It holds the selection and replication logic.
- The top level holds the counter, word/mode registers, pop logic and the output register stage. Registers use the shared `register.sv` DFF primitives.

## Test plan
- Mode 0 test:
  - Stimulus: FIFO words 0x00112233, 0x00445566, 0x00778899; `de_i` high for 3 cycles.
  - Required response: 3 pops in cycles 0–2; RGB 11/22/33, 44/55/66, 77/88/99 in cycles 1–3; `de_o` high in cycles 1–3.
- Mode 1 test:
  - Stimulus: word 0xF80007E0 with `de_i` high for 2 cycles.
  - Required response: exactly 1 pop; outputs 00/FF/00, then FF/00/00.
- Mode 2 test:
  - Stimulus: word 0x031CE0FF with `de_i` high for 4 cycles.
  - Required response: outputs FF/FF/FF, FF/00/00, 00/FF/00, 00/00/FF; exactly 1 pop.
- Underflow test:
  - Stimulus: `fifo_empty_i`=1 at `idx_q`=0 while `de_i` is high.
  - Required response: `fifo_rd_o`=0; a black pixel and an `underflow_o` pulse one cycle later; the next pixel fetches fresh once the FIFO is non-empty.
- Frame boundary test:
  - Stimulus: in mode 2, `vend_i` after 2 pixels of a word; `mode_i` changed to 0 mid-frame.
  - Required response: old mode is kept until `vend_i`; then `idx_q`=0, and the first `de_i` of the next frame pops a new word decoded as RGB888.
- Reset and enable test:
  - Stimulus: `rst_n_i` asserted mid-line; separately, `en_i` dropped mid-line.
  - Required response: on reset, all outputs 0 immediately. On `en_i` low, no pops and RGB outputs 0, while `hsync_o`/`vsync_o` keep tracking their inputs with 1-cycle delay.

Source files
------------

// File: rtl/vga_pixfmt_pkg.sv
// Shared pixel-format codes and helpers for the VGA pixel formatter.
// Mode 3 is reserved and decodes exactly like RGB888 everywhere.
package vga_pixfmt_pkg;

  typedef enum logic [1:0] {
    VGA_MODE_RGB888 = 2'd0,
    VGA_MODE_RGB565 = 2'd1,
    VGA_MODE_RGB332 = 2'd2,
    VGA_MODE_RSVD   = 2'd3
  } vga_mode_e;

  localparam int VGA_PIX_WIDTH = 24;
  localparam int VGA_WORD_WIDTH = 32;

  // Index of the last pixel in a word: ppw-1 for the given format.
  function automatic logic [1:0] idx_last(input logic [1:0] mode);
    logic [1:0] last;
    case (mode)
      VGA_MODE_RGB565: last = 2'd1;
      VGA_MODE_RGB332: last = 2'd3;
      default:         last = 2'd0;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/vga_pixfmt_pixexp.sv
// Pixel selection and RGB888 expansion (MSB replication) from a packed word.
// Purely combinational; the caller chooses the word and the pixel index.
module vga_pixexp
  import vga_pixfmt_pkg::*;
(
  input  logic [1:0]               mode,
  input  logic [VGA_WORD_WIDTH-1:0] word,
  input  logic [1:0]               idx,
  output logic [VGA_PIX_WIDTH-1:0] rgb
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    half_sel = idx[0] ? word[31:16] : word[15:0];
    case (idx)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
  end

  always_comb begin
    rgb = word[23:0];
    case (mode)
      VGA_MODE_RGB565: begin
        rgb = {half_sel[15:11], half_sel[15:13],
               half_sel[10:5],  half_sel[10:9],
               half_sel[4:0],   half_sel[4:2]};
      end
      VGA_MODE_RGB332: begin
        rgb = {byte_sel[7:5], byte_sel[7:5], byte_sel[7:6],
               byte_sel[4:2], byte_sel[4:2], byte_sel[4:3],
               {4{byte_sel[1:0]}}};
      end
      default: rgb = word[23:0];
    endcase
  end

endmodule

// File: rtl/vga_pixfmt.sv
// VGA pixel formatter: pops FWFT pixel words, unpacks them to RGB888 and
// registers colour and syncs together so they leave the block aligned.
module vga_pixfmt
  import vga_pixfmt_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          en_i,
  input  logic [1:0]    mode_i,
  input  logic          de_i,
  input  logic          hsync_i,
  input  logic          vsync_i,
  input  logic          vend_i,
  input  logic          fifo_empty_i,
  input  logic [DW-1:0] fifo_data_i,
  output logic          fifo_rd_o,
  output logic [7:0]    red_o,
  output logic [7:0]    green_o,
  output logic [7:0]    blue_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          de_o,
  output logic          underflow_o
);

  logic [1:0]    idx_q, idx_d;
  logic [DW-1:0] word_q, word_d;
  logic [1:0]    mode_q, mode_d;

  logic [VGA_PIX_WIDTH-1:0] pix_q, pix_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic de_q, de_d;
  logic underflow_q, underflow_d;

  logic                     fetch;
  logic                     at_head;
  logic                     pop;
  logic                     underflow;
  logic [DW-1:0]            src_word;
  logic [VGA_PIX_WIDTH-1:0] exp_rgb;

  always_comb begin
    fetch     = en_i && de_i;
    at_head   = (idx_q == 2'd0);
    pop       = fetch && at_head && !fifo_empty_i;
    underflow = fetch && at_head && fifo_empty_i;
    // At the head of a word the pixel comes straight off the FIFO output.
    src_word  = at_head ? fifo_data_i : word_q;
  end

  vga_pixexp u_pixexp (
    .mode (mode_q),
    .word (src_word),
    .idx  (idx_q),
    .rgb  (exp_rgb)
  );

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    mode_d = mode_q;

    if (pop) begin
      word_d = fifo_data_i;
    end

    // Frame end and disable both realign packing and pick up a new format.
    if (!en_i || vend_i) begin
      idx_d  = 2'd0;
      mode_d = mode_i;
    end else if (fetch) begin
      idx_d = (idx_q == idx_last(mode_q)) ? 2'd0 : idx_q + 2'd1;
    end
  end

  always_comb begin
    pix_d       = (fetch && !underflow) ? exp_rgb : '0;
    de_d        = fetch;
    underflow_d = underflow;
    hsync_d     = hsync_i;
    vsync_d     = vsync_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idx_q  <= 2'd0;
      word_q <= '0;
      mode_q <= 2'd0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
      mode_q <= mode_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pix_q       <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      de_q        <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pix_q       <= pix_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      underflow_q <= underflow_d;
    end
  end

  assign fifo_rd_o   = pop;
  assign red_o       = pix_q[23:16];
  assign green_o     = pix_q[15:8];
  assign blue_o      = pix_q[7:0];
  assign hsync_o     = hsync_q;
  assign vsync_o     = vsync_q;
  assign de_o        = de_q;
  assign underflow_o = underflow_q;

endmodule
